pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Consumer of the load-use bubble request from hazard detection. Arbitrates it with memory-busy
//  freezes, taken-branch flushes and HLT. Drives write enables / NOP inserts for PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB of the 5-stage 16-bit pipeline. Sits in the control tree beside hazard detection.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive mem_busy cycles before sticky timeout error (1..2^CNT_W-1)
//  CNT_W        16   width of timeout counter and perf counters
// PORTS
//  clk             in   1      clock; single clock domain
//  rst             in   1      synchronous, active-high reset
//  bubble          in   1      load-use stall request; combinational, from hazard detection
//  imem_busy       in   1      fetch not ready this cycle
//  mem_busy        in   1      data memory not ready; whole pipeline must freeze
//  branch_taken_ex in   1      taken branch/jump resolved in EX; one-cycle pulse
//  halt_wb         in   1      HLT instruction is in WB
//  pc_we           out  1      PC register write enable
//  if_id_we        out  1      IF/ID write enable
//  if_id_flush     out  1      load NOP (16'h0000) into IF/ID
//  id_ex_nop       out  1      load NOP control bundle into ID/EX
//  back_we         out  1      EX/MEM and MEM/WB write enable
//  halted          out  1      processor halted (sticky until rst)
//  mem_timeout     out  1      sticky error: mem_busy exceeded MEM_TIMEOUT
//  state           out  2      FSM state, for debug
// BEHAVIOUR
//  - States: RUN=0, MEM_WAIT=1, HALT=2, ERR=3.
//  - Reset: state=RUN, flush_pending=0, tcnt=0, halted=0, mem_timeout=0.
//  - Enables are combinational from state+inputs: 0-cycle latency. Only state, flush_pending and
//    counters are registered. Priority per cycle: rst > halt_wb > mem_busy > flush > bubble > imem_busy.
//  - RUN, no requests: all enables 1; flush/nop 0.
//  - halt_wb: all enables 0; next state HALT; halted=1 from the next cycle.
//  - HALT/ERR: all enables 0; leave only on rst.
//  - mem_busy (RUN or MEM_WAIT): pc_we=if_id_we=back_we=0; flush/nop 0; state->MEM_WAIT; tcnt++.
//    If branch_taken_ex coincides, set flush_pending=1.
//  - Timeout: tcnt==MEM_TIMEOUT while mem_busy -> next state ERR, mem_timeout=1.
//  - MEM_WAIT with mem_busy=0: tcnt<=0; state->RUN; evaluate remaining priorities this same cycle.
//  - Flush (branch_taken_ex | flush_pending, not frozen): pc_we=1, if_id_flush=1, id_ex_nop=1,
//    back_we=1; clears flush_pending. Flush overrides bubble; the stalled instr is squashed.
//  - Bubble (no flush): pc_we=0, if_id_we=0, id_ex_nop=1, back_we=1; one cycle per assertion.
//  - imem_busy only: pc_we=0, if_id_we=1, if_id_flush=1 (NOP into pipe), back_we=1.
//  - bubble and imem_busy together: bubble rule wins; IF/ID holds.
//  - rst mid-MEM_WAIT or mid-HALT returns to RUN next cycle; flush_pending is discarded.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined:
//   - Adds outputs stall_cycles[CNT_W], flush_count[CNT_W], bubble_count[CNT_W].
//   - Counters are saturating, reset to 0, and frozen in HALT.
//   - stall_cycles counts any cycle with pc_we=0 in RUN/MEM_WAIT.
//  Not defined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared header stall_ctrl_defs.vh: state encodings ST_RUN/ST_MEM_WAIT/ST_HALT/ST_ERR and
//    NOP instr constant 16'h0000. The header is shared with hazard detection and the pipeline registers.
//  - One sub-module sat_counter (param W; inputs clk, rst, clr, inc; output count), used for tcnt
//    and the perf counters.
//  - Rest is one always @(posedge clk) state block plus one combinational enable block.
// TESTING
//  - Reset: rst=1 for 2 cycles with all inputs 1 -> state=0, halted=0, mem_timeout=0.
//    First cycle after with no requests -> all we=1.
//  - Load-use: bubble=1 for 1 cycle -> pc_we=0, if_id_we=0, id_ex_nop=1, back_we=1 that cycle.
//    Next cycle -> all we=1.
//  - Branch + bubble same cycle -> pc_we=1, if_id_flush=1, id_ex_nop=1. No hold.
//  - mem_busy 3 cycles with branch_taken_ex pulse in cycle 1:
//    - cycles 1-3: all we=0, state=1.
//    - cycle 4: flush applied (if_id_flush=1, pc_we=1), state=0.
//  - MEM_TIMEOUT=4, mem_busy held 6 cycles -> mem_timeout=1 and state=3 after cycle 5.
//    Stays set with mem_busy=0 until rst.
//  - halt_wb pulse -> next cycle halted=1, state=2, all we=0 for 10 cycles. rst -> state=0.
//    With STALL_PERF_CNT_EN, stall_cycles unchanged while halted.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings, the NOP
// instruction word and the enable-bundle type with its per-rule constant values.
package pipeline_stall_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;
    localparam logic [1:0] ST_ERR      = 2'd3;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_nop;
        logic back_we;
    } stall_en_t;

    localparam stall_en_t EN_RUN    = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_nop: 1'b0, back_we: 1'b1};
    localparam stall_en_t EN_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_nop: 1'b0, back_we: 1'b0};
    // Flush writes a NOP into IF/ID, so IF/ID must be enabled for the load.
    localparam stall_en_t EN_FLUSH  = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1, id_ex_nop: 1'b1, back_we: 1'b1};
    localparam stall_en_t EN_BUBBLE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0, id_ex_nop: 1'b1, back_we: 1'b1};
    localparam stall_en_t EN_IFETCH = '{pc_we: 1'b0, if_id_we: 1'b1, if_id_flush: 1'b1, id_ex_nop: 1'b0, back_we: 1'b1};

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the memory-wait
// timeout counter and the optional performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush arbiter for the 5-stage pipeline. Define STALL_PERF_CNT_EN to add
// saturating stall/flush/bubble performance counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble,
    input  logic             imem_busy,
    input  logic             mem_busy,
    input  logic             branch_taken_ex,
    input  logic             halt_wb,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_nop,
    output logic             back_we,
    output logic             halted,
    output logic             mem_timeout,
`ifdef STALL_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] bubble_count,
`endif
    output logic [1:0]       state
);

    logic             flush_pending;
    logic             active;
    logic             timeout_hit;
    logic             tcnt_inc;
    logic [CNT_W-1:0] tcnt;
    stall_en_t        en;

    assign active      = (state == ST_RUN) || (state == ST_MEM_WAIT);
    assign timeout_hit = (tcnt == CNT_W'(MEM_TIMEOUT));
    // tcnt only survives across consecutive mem_busy cycles; anything else zeroes it.
    assign tcnt_inc    = active && !halt_wb && mem_busy && !timeout_hit;

    sat_counter #(.W(CNT_W)) u_tcnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (!tcnt_inc),
        .inc   (tcnt_inc),
        .count (tcnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (halt_wb) begin
                        state         <= ST_HALT;
                        flush_pending <= 1'b0;
                    end else if (mem_busy) begin
                        if (timeout_hit) begin
                            state         <= ST_ERR;
                            flush_pending <= 1'b0;
                        end else begin
                            state <= ST_MEM_WAIT;
                            // A branch resolved during a freeze is replayed on release.
                            if (branch_taken_ex) flush_pending <= 1'b1;
                        end
                    end else begin
                        state         <= ST_RUN;
                        flush_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        en = EN_FREEZE;
        if (active && !halt_wb && !mem_busy) begin
            if (branch_taken_ex || flush_pending) en = EN_FLUSH;
            else if (bubble)                      en = EN_BUBBLE;
            else if (imem_busy)                   en = EN_IFETCH;
            else                                  en = EN_RUN;
        end
    end

    assign pc_we       = en.pc_we;
    assign if_id_we    = en.if_id_we;
    assign if_id_flush = en.if_id_flush;
    assign id_ex_nop   = en.id_ex_nop;
    assign back_we     = en.back_we;
    assign halted      = (state == ST_HALT);
    assign mem_timeout = (state == ST_ERR);

`ifdef STALL_PERF_CNT_EN
    // Counting is gated by active, so the counters hold still in HALT and ERR.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (active && !en.pc_we),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (active && en == EN_FLUSH),
        .count (flush_count)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (active && en == EN_BUBBLE),
        .count (bubble_count)
    );
`endif

endmodule
